// File: rtl/uart_pkg.sv
// Shared frame constants and FSM state encodings for the configurable UART.
// Pure declarations: no latency.
// No flow control of its own.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_st_t;

    typedef uart_st_t rx_st_t;
    typedef uart_st_t tx_st_t;

    // Mode 2'b11 is reserved and behaves as "no parity".
    function automatic logic par_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic par_odd(input logic [1:0] mode);
        return mode == PAR_ODD;
    endfunction

endpackage

// File: rtl/uart_fifo_lvl.sv
// Synchronous FIFO with occupancy level and first-word fall-through read data.
// Latency: a push is visible at r_data one clk later.
// Backpressure: push on full is dropped unless a pop happens in the same clk.
module uart_fifo_lvl #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [W:0]   level,
    output logic [B-1:0] r_data
);
    localparam int DEPTH = 1 << W;
    localparam logic [W:0] FULL_LVL = {1'b1, {W{1'b0}}};

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] wptr;
    logic [W-1:0] rptr;
    logic         do_rd;
    logic         do_wr;

    assign empty  = (level == '0);
    assign full   = (level == FULL_LVL);
    assign do_rd  = rd && !empty;
    assign do_wr  = wr && (!full || do_rd);
    // Storage is not reset, so the head is masked to zero while empty.
    assign r_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= w_data;
    end

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: baud divisor, parity and stop bits set from ports.
// Latency: tx falls 2 clk after wr_uart into an idle TX; RX byte lands 2 clk after the stop sample.
// Backpressure: TX writes on full are dropped; RX bytes on full are dropped and flag rx_ovr.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int DVSR_BITS = 16,
    parameter int FIFO_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DVSR_BITS-1:0] dvsr,
    input  logic [1:0]           par_mode,
    input  logic                 stop2,
    input  logic                 rx,
    input  logic                 rd_uart,
    input  logic                 wr_uart,
    input  logic [DBIT-1:0]      w_data,
    input  logic                 clr_ovr,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_full,
    output logic [FIFO_W:0]      tx_level,
    output logic                 rx_empty,
    output logic [FIFO_W:0]      rx_level,
    output logic [DBIT-1:0]      r_data,
    output logic                 r_perr,
    output logic                 r_ferr,
    output logic                 rx_ovr
);
    localparam int SW = $clog2(2 * SB_TICK);
    localparam int NB = $clog2(DBIT);
    localparam logic [SW-1:0] S_HALF  = SW'(SB_TICK / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_LAST2 = SW'(2 * SB_TICK - 1);
    localparam logic [NB-1:0] N_LAST  = NB'(DBIT - 1);

    typedef struct packed {
        logic            ferr;
        logic            perr;
        logic [DBIT-1:0] dat;
    } rx_ent_t;

    // Baud tick generator; dvsr of 0 or 1 ticks every clk.
    logic [DVSR_BITS-1:0] bcnt;
    logic [DVSR_BITS-1:0] blim;
    logic                 tick;

    assign blim = (dvsr > DVSR_BITS'(1)) ? dvsr - DVSR_BITS'(1) : '0;
    assign tick = (bcnt == blim);

    always_ff @(posedge clk) begin
        if (reset) bcnt <= '0;
        else       bcnt <= (bcnt >= blim) ? '0 : bcnt + 1'b1;
    end

    logic rx_q1;
    logic rx_sync;

    always_ff @(posedge clk) begin
        if (reset) {rx_sync, rx_q1} <= 2'b11;
        else       {rx_sync, rx_q1} <= {rx_q1, rx};
    end

    rx_st_t          rx_st;
    logic [SW-1:0]   rx_s;
    logic [NB-1:0]   rx_n;
    logic [DBIT-1:0] rx_b;
    logic [1:0]      rx_mode;
    logic            rx_perr;
    logic            rx_push;
    rx_ent_t         rx_ent;
    rx_ent_t         rx_head;
    logic            rx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st   <= ST_IDLE;
            rx_s    <= '0;
            rx_n    <= '0;
            rx_b    <= '0;
            rx_mode <= PAR_NONE;
            rx_perr <= 1'b0;
            rx_push <= 1'b0;
            rx_ent  <= '0;
        end else begin
            rx_push <= 1'b0;
            case (rx_st)
                ST_IDLE: if (!rx_sync) begin
                    rx_st   <= ST_START;
                    rx_s    <= '0;
                    rx_mode <= par_mode;
                    rx_perr <= 1'b0;
                end
                ST_START: if (tick) begin
                    if (rx_s == S_HALF) begin
                        rx_s  <= '0;
                        rx_n  <= '0;
                        rx_st <= rx_sync ? ST_IDLE : ST_DATA;
                    end else rx_s <= rx_s + 1'b1;
                end
                ST_DATA: if (tick) begin
                    if (rx_s == S_LAST) begin
                        rx_s <= '0;
                        rx_b <= {rx_sync, rx_b[DBIT-1:1]};
                        if (rx_n == N_LAST) rx_st <= par_en(rx_mode) ? ST_PAR : ST_STOP;
                        else                rx_n  <= rx_n + 1'b1;
                    end else rx_s <= rx_s + 1'b1;
                end
                ST_PAR: if (tick) begin
                    if (rx_s == S_LAST) begin
                        rx_s    <= '0;
                        rx_perr <= rx_sync ^ (^rx_b) ^ par_odd(rx_mode);
                        rx_st   <= ST_STOP;
                    end else rx_s <= rx_s + 1'b1;
                end
                ST_STOP: if (tick) begin
                    if (rx_s == S_LAST) begin
                        rx_s    <= '0;
                        rx_push <= 1'b1;
                        rx_ent  <= '{ferr: !rx_sync, perr: rx_perr, dat: rx_b};
                        rx_st   <= ST_IDLE;
                    end else rx_s <= rx_s + 1'b1;
                end
                default: rx_st <= ST_IDLE;
            endcase
        end
    end

    // A pop in the same clk makes room, so only an unserved push is an overrun.
    always_ff @(posedge clk) begin
        if (reset)                                rx_ovr <= 1'b0;
        else if (rx_push && rx_full && !rd_uart) rx_ovr <= 1'b1;
        else if (clr_ovr)                         rx_ovr <= 1'b0;
    end

    uart_fifo_lvl #(.B(DBIT + 2), .W(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_push),
        .w_data (rx_ent),
        .empty  (rx_empty),
        .full   (rx_full),
        .level  (rx_level),
        .r_data (rx_head)
    );

    assign r_data = rx_head.dat;
    assign r_perr = rx_head.perr;
    assign r_ferr = rx_head.ferr;

    tx_st_t          tx_st;
    logic [SW-1:0]   tx_s;
    logic [NB-1:0]   tx_n;
    logic [DBIT-1:0] tx_b;
    logic            tx_par;
    logic [1:0]      tx_mode;
    logic            tx_stop2;
    logic            tx_empty;
    logic            tx_pop;
    logic [DBIT-1:0] tx_head;

    assign tx_busy = (tx_st != ST_IDLE);
    assign tx_pop  = (tx_st == ST_STOP) && tick && (tx_s == (tx_stop2 ? S_LAST2 : S_LAST));

    // tx is driven from the state of the previous clk, so every bit shifts by one clk uniformly.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st    <= ST_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_par   <= 1'b0;
            tx_mode  <= PAR_NONE;
            tx_stop2 <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (tx_st)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (!tx_empty) begin
                        tx_st    <= ST_START;
                        tx_s     <= '0;
                        tx_n     <= '0;
                        tx_b     <= tx_head;
                        tx_par   <= (^tx_head) ^ par_odd(par_mode);
                        tx_mode  <= par_mode;
                        tx_stop2 <= stop2;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (tick) begin
                        if (tx_s == S_LAST) begin
                            tx_s  <= '0;
                            tx_st <= ST_DATA;
                        end else tx_s <= tx_s + 1'b1;
                    end
                end
                ST_DATA: begin
                    tx <= tx_b[0];
                    if (tick) begin
                        if (tx_s == S_LAST) begin
                            tx_s <= '0;
                            tx_b <= tx_b >> 1;
                            if (tx_n == N_LAST) tx_st <= par_en(tx_mode) ? ST_PAR : ST_STOP;
                            else                tx_n  <= tx_n + 1'b1;
                        end else tx_s <= tx_s + 1'b1;
                    end
                end
                ST_PAR: begin
                    tx <= tx_par;
                    if (tick) begin
                        if (tx_s == S_LAST) begin
                            tx_s  <= '0;
                            tx_st <= ST_STOP;
                        end else tx_s <= tx_s + 1'b1;
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (tx_pop) begin
                        tx_s  <= '0;
                        tx_st <= ST_IDLE;
                    end else if (tick) tx_s <= tx_s + 1'b1;
                end
                default: tx_st <= ST_IDLE;
            endcase
        end
    end

    uart_fifo_lvl #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (wr_uart),
        .w_data (w_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .level  (tx_level),
        .r_data (tx_head)
    );

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: loopback and bench-driven RX frames, scoreboard on received entries.
module tb_uart_cfg;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dvsr;
    logic [1:0]  par_mode;
    logic        stop2;
    logic        rx;
    logic        rd_uart;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        clr_ovr;
    logic        tx;
    logic        tx_busy;
    logic        tx_full;
    logic [4:0]  tx_level;
    logic        rx_empty;
    logic [4:0]  rx_level;
    logic [7:0]  r_data;
    logic        r_perr;
    logic        r_ferr;
    logic        rx_ovr;

    logic        lb;
    logic        rx_bit;
    logic        auto_rd;
    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  sb_q[$];

    always #5 clk = ~clk;

    assign rx = lb ? tx : rx_bit;

    uart_cfg dut (
        .clk      (clk),
        .reset    (reset),
        .dvsr     (dvsr),
        .par_mode (par_mode),
        .stop2    (stop2),
        .rx       (rx),
        .rd_uart  (rd_uart),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .clr_ovr  (clr_ovr),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_full  (tx_full),
        .tx_level (tx_level),
        .rx_empty (rx_empty),
        .rx_level (rx_level),
        .r_data   (r_data),
        .r_perr   (r_perr),
        .r_ferr   (r_ferr),
        .rx_ovr   (rx_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Scoreboard reader: pops every head entry and compares {ferr, perr, data}.
    initial begin
        rd_uart = 1'b0;
        forever begin
            @(negedge clk);
            rd_uart = 1'b0;
            if (auto_rd && !reset && !rx_empty) begin
                if (sb_q.size() == 0) chk("sb_unexpected", sb_q.size(), 1);
                else                  chk("sb_rx", {r_ferr, r_perr, r_data}, sb_q.pop_front());
                rd_uart = 1'b1;
            end
        end
    end

    task automatic wait_tx(input logic lvl, input int budget);
        int n = 0;
        while (tx !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_tx", tx, lvl);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || !rx_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb_q.size(), 0);
    endtask

    task automatic put_tx(input logic [7:0] d);
        w_data  = d;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    // Stop bit is held for 3/4 of a bit so a low stop cannot be seen as a new start.
    task automatic send_rx(input logic [7:0] d, input logic use_par, input logic pbit, input logic stopv);
        int bitc;
        bitc = 16 * int'(dvsr);
        rx_bit = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = d[i];
            repeat (bitc) @(negedge clk);
        end
        if (use_par) begin
            rx_bit = pbit;
            repeat (bitc) @(negedge clk);
        end
        rx_bit = stopv;
        repeat (bitc * 12 / 16) @(negedge clk);
        rx_bit = 1'b1;
        repeat (bitc * 4 / 16 + 8) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int min_lvl;
        reset    = 1'b1;
        dvsr     = 16'd4;
        par_mode = PAR_NONE;
        stop2    = 1'b0;
        rx_bit   = 1'b1;
        lb       = 1'b0;
        auto_rd  = 1'b0;
        wr_uart  = 1'b0;
        w_data   = 8'h00;
        clr_ovr  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_tx", tx, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_rx_ovr", rx_ovr, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_r_flags", {r_ferr, r_perr}, 0);

        reset   = 1'b0;
        lb      = 1'b1;
        auto_rd = 1'b1;
        @(negedge clk);

        // 8N1 loopback of 0xA5 at dvsr=4: ten bits of 64 clk each.
        sb_q.push_back({2'b00, 8'hA5});
        put_tx(8'hA5);
        @(negedge clk);
        chk("tx_lat_early", tx, 1);
        @(negedge clk);
        chk("tx_lat", tx, 0);
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        // The free-running tick can shorten the start bit by up to dvsr-1 clk.
        chk("frame_len_640", (n + 1 >= 637) && (n + 1 <= 640), 1);
        wait_drain(2000);

        // Parity bit on the wire for 0x07: 1 in even mode, 0 in odd mode.
        par_mode = PAR_EVEN;
        sb_q.push_back({2'b00, 8'h07});
        put_tx(8'h07);
        wait_tx(1'b0, 100);
        repeat (64 * 9 + 32) @(negedge clk);
        chk("par_even_bit", tx, 1);
        wait_drain(2000);

        par_mode = PAR_ODD;
        sb_q.push_back({2'b00, 8'h07});
        put_tx(8'h07);
        wait_tx(1'b0, 100);
        repeat (64 * 9 + 32) @(negedge clk);
        chk("par_odd_bit", tx, 0);
        wait_drain(2000);

        // Bench-driven frames: wrong parity, then a low stop bit.
        lb       = 1'b0;
        par_mode = PAR_EVEN;
        sb_q.push_back({2'b01, 8'h07});
        send_rx(8'h07, 1'b1, 1'b0, 1'b1);
        sb_q.push_back({2'b10, 8'h07});
        send_rx(8'h07, 1'b1, 1'b1, 1'b0);
        wait_drain(2000);

        // Overrun: 17 frames with nobody reading; only the first 16 are kept.
        par_mode = PAR_NONE;
        auto_rd  = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb_q.push_back({2'b00, 8'h10 + 8'(i)});
            send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        end
        chk("ovr_rx_level", rx_level, 16);
        chk("ovr_set", rx_ovr, 1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_clr", rx_ovr, 0);
        auto_rd = 1'b1;
        wait_drain(200);

        // TX FIFO fill: 17 writes back-to-back, the last one dropped.
        dvsr = 16'd2;
        lb   = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb_q.push_back({2'b00, 8'h30 + 8'(i)});
            w_data  = 8'h30 + 8'(i);
            wr_uart = 1'b1;
            @(negedge clk);
        end
        wr_uart = 1'b0;
        chk("tx_full_16", tx_full, 1);
        chk("tx_level_16", tx_level, 16);

        // Hold a write across the first pop: push and pop land in the same clk.
        w_data  = 8'hEE;
        wr_uart = 1'b1;
        min_lvl = 16;
        n = 0;
        while (tx_busy && n < 1000) begin
            @(negedge clk);
            if (int'(tx_level) < min_lvl) min_lvl = int'(tx_level);
            n++;
        end
        wr_uart = 1'b0;
        sb_q.push_back({2'b00, 8'hEE});
        chk("tx_wr_rd_full", min_lvl, 16);
        chk("tx_full_hold", tx_full, 1);
        wait_drain(12000);

        // Two stop bits: high span between back-to-back 0x00 frames is 32 ticks plus one idle clk.
        stop2 = 1'b1;
        sb_q.push_back({2'b00, 8'h00});
        sb_q.push_back({2'b00, 8'h00});
        put_tx(8'h00);
        put_tx(8'h00);
        wait_tx(1'b0, 100);
        wait_tx(1'b1, 1000);
        n = 0;
        while (tx === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("stop2_span", n, 32 * 2 + 1);
        stop2 = 1'b0;
        wait_drain(2000);

        // Reset in the middle of a data bit aborts the frame at once.
        dvsr = 16'd4;
        lb   = 1'b0;
        put_tx(8'h55);
        wait_tx(1'b0, 100);
        repeat (64 * 5 / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_tx_level", tx_level, 0);
        chk("mid_rst_rx_level", rx_level, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // A 0.3-bit low glitch is rejected by the start-bit check.
        rx_bit = 1'b0;
        repeat (64 * 3 / 10) @(negedge clk);
        rx_bit = 1'b1;
        repeat (64 * 11) @(negedge clk);
        chk("glitch_level", rx_level, 0);
        chk("glitch_empty", rx_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
